// File: rtl/hazard_scoreboard.sv
// Hazard detection unit for the 5-stage RISC-V pipeline: load-use and branch-operand stalls,
// a per-register scoreboard for long-latency writes with a WAW guard, a cause code and a stall counter.
module hazard_scoreboard #(
   parameter int NREG           = 32,
   parameter int AW             = 5,
   parameter bit ZERO_HARDWIRED = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs1,
   input  logic [AW-1:0]    id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [AW-1:0]    id_rd,
   input  logic             id_wr_en,
   input  logic             id_long,
   input  logic             id_is_branch,
   input  logic             flush,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic [AW-1:0]    ex_rd,
   input  logic             mem_memread,
   input  logic [AW-1:0]    mem_rd,
   input  logic             wb_long_valid,
   input  logic [AW-1:0]    wb_long_rd,
   output logic             stall,
   output logic [1:0]       hazard_cause,
   output logic [NREG-1:0]  busy_vec,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int NIDX = 1 << AW;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_LOAD_USE   = 2'd1,
      CAUSE_BRANCH     = 2'd2,
      CAUSE_SCOREBOARD = 2'd3
   } cause_e;

   function automatic logic is_zero_reg(input logic [AW-1:0] r);
      return ZERO_HARDWIRED && (r == '0);
   endfunction

   logic [NREG-1:0]  busy_q;
   logic [NREG-1:0]  done_dec;
   logic [NREG-1:0]  issue_dec;
   logic [NREG-1:0]  eff_busy;
   logic [NIDX-1:0]  eff_busy_ext;
   logic [CNT_W-1:0] cnt_q;

   logic   rs1_live, rs2_live, rd_live;
   logic   ex_hit, mem_hit;
   logic   sb_hit, load_use, branch_hz;
   logic   active, issue;
   cause_e cause;

   // ------------------------------------------------------------------
   // Source/destination qualification: x0 never participates when hardwired.
   // ------------------------------------------------------------------
   assign rs1_live = id_use_rs1 && !is_zero_reg(id_rs1);
   assign rs2_live = id_use_rs2 && !is_zero_reg(id_rs2);
   assign rd_live  = id_wr_en   && !is_zero_reg(id_rd);

   assign ex_hit  = (rs1_live && (id_rs1 == ex_rd))  || (rs2_live && (id_rs2 == ex_rd));
   assign mem_hit = (rs1_live && (id_rs1 == mem_rd)) || (rs2_live && (id_rs2 == mem_rd));

   // ------------------------------------------------------------------
   // Scoreboard decode. A completing write counts as already done because
   // the register file is write-first.
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      done_dec     = '0;
      issue_dec    = '0;
      eff_busy_ext = '0;
      for (int i = 0; i < NREG; i++) begin
         done_dec[i]  = wb_long_valid && (wb_long_rd == AW'(i));
         issue_dec[i] = issue && (id_rd == AW'(i));
      end
      eff_busy                   = busy_q & ~done_dec;
      eff_busy_ext[NREG-1:0]     = eff_busy;
   end

   assign sb_hit = (rs1_live && eff_busy_ext[id_rs1]) ||
                   (rs2_live && eff_busy_ext[id_rs2]) ||
                   (rd_live  && eff_busy_ext[id_rd]);

   assign load_use  = ex_memread && ex_hit;
   assign branch_hz = id_is_branch && ((ex_regwrite && ex_hit) || (mem_memread && mem_hit));

   assign active = id_valid && !rst && !flush;

   // Priority: scoreboard/WAW, then load-use, then branch operand.
   always_comb begin
      stall = 1'b0;
      cause = CAUSE_NONE;
      if (active) begin
         if (sb_hit) begin
            stall = 1'b1;
            cause = CAUSE_SCOREBOARD;
         end else if (load_use) begin
            stall = 1'b1;
            cause = CAUSE_LOAD_USE;
         end else if (branch_hz) begin
            stall = 1'b1;
            cause = CAUSE_BRANCH;
         end
      end
   end

   assign hazard_cause = cause;

   assign issue = id_valid && !stall && !flush && id_long && rd_live;

   // ------------------------------------------------------------------
   // Scoreboard state: set beats clear on the same register; flush leaves
   // in-flight entries alone since those ops still complete.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~done_dec) | issue_dec;
      end
   end

   assign busy_vec = busy_q;

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt = cnt_q;

endmodule
